// File: rtl/wb_pkg.sv
// Shared types for the Wishbone-style master: FSM state encoding and the
// command word stored in the command FIFO.
package wb_pkg;

  localparam int WB_AW = 8;
  localparam int WB_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } wbm_state_t;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] wdata;
  } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command FIFO of DEPTH wb_cmd_t entries. A full FIFO refuses a push even
// when a pop happens in the same cycle; there is no pass-through.
module wb_cmd_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  wb_cmd_t din_i,
  input  logic    pop_i,
  output wb_cmd_t dout_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_cmd_t        mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone-style bus master: buffers commands, issues each as one strobed
// transaction with an ack timeout, and returns rdata/err on a response port.
module wb_master_ctrl
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          wb_we,
  output logic          wb_strb,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_wdata,
  input  logic [DW-1:0] wb_rdata,
  input  logic          wb_ack
);

  localparam int TW = $clog2(TIMEOUT);

  wbm_state_t    state_q;
  logic [TW-1:0] tmo_cnt_q;
  logic          wb_we_q;
  logic          wb_strb_q;
  logic [AW-1:0] wb_addr_q;
  logic [DW-1:0] wb_wdata_q;
  logic          rsp_valid_q;
  logic          rsp_we_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          rsp_err_q;

  wb_cmd_t fifo_din;
  wb_cmd_t fifo_dout;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_pop;

  assign fifo_din  = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  wb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_strb_q   <= 1'b0;
      wb_addr_q   <= '0;
      wb_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            wb_we_q    <= fifo_dout.we;
            wb_addr_q  <= fifo_dout.addr;
            wb_wdata_q <= fifo_dout.wdata;
            wb_strb_q  <= 1'b1;
            tmo_cnt_q  <= '0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // Ack is tested first so an ack in the final timeout cycle still succeeds.
          if (wb_ack) begin
            rsp_rdata_q <= wb_we_q ? '0 : wb_rdata;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= wb_we_q;
            rsp_valid_q <= 1'b1;
            wb_strb_q   <= 1'b0;
            state_q     <= RESP;
          end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_we_q    <= wb_we_q;
            rsp_valid_q <= 1'b1;
            wb_strb_q   <= 1'b0;
            state_q     <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_we     = wb_we_q;
  assign wb_strb   = wb_strb_q;
  assign wb_addr   = wb_addr_q;
  assign wb_wdata  = wb_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Scoreboard bench for wb_master_ctrl paired with a behavioural memory slave;
// the slave ack can be tied low or forced in the last timeout cycle.
module tb_wb_master_ctrl;
  import wb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_we;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       wb_we;
  logic       wb_strb;
  logic [7:0] wb_addr;
  logic [7:0] wb_wdata;
  logic [7:0] wb_rdata;
  logic       wb_ack;

  always #5 clk = ~clk;

  wb_master_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_we     (wb_we),
    .wb_strb   (wb_strb),
    .wb_addr   (wb_addr),
    .wb_wdata  (wb_wdata),
    .wb_rdata  (wb_rdata),
    .wb_ack    (wb_ack)
  );

  // Memory slave: acks one cycle after seeing strb, then idles for a cycle.
  logic [7:0] mem [256];
  logic       mem_ack;
  logic [7:0] mem_rdata;
  int         strb_pe;
  logic       force_ack = 1'b0;
  int         mode = 0;   // 0 memory, 1 ack tied low, 2 ack forced in last cycle

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
      strb_pe   <= 0;
    end else begin
      if (wb_strb && !mem_ack) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[wb_addr];
        if (wb_we) mem[wb_addr] <= wb_wdata;
      end else begin
        mem_ack <= 1'b0;
      end
      strb_pe <= wb_strb ? strb_pe + 1 : 0;
    end
  end

  always @(negedge clk) force_ack <= wb_strb && (strb_pe == 15);

  assign wb_ack   = (mode == 0) ? mem_ack : ((mode == 2) ? force_ack : 1'b0);
  assign wb_rdata = (mode == 2) ? 8'h3C : mem_rdata;

  typedef struct packed {
    logic       we;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata %0h with empty scoreboard", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_we", rsp_we, e.we);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
      end
    end
  end

  logic gap_on = 1'b0;
  logic prev_strb = 1'b0;
  int   low_cnt = 0;
  int   rises = 0;

  always @(negedge clk) begin
    if (wb_strb && !prev_strb) begin
      rises <= rises + 1;
      if (gap_on) check("strb_gap", low_cnt >= 1, 1);
    end
    low_cnt   <= wb_strb ? 0 : low_cnt + 1;
    prev_strb <= wb_strb;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] er, input logic ee);
    bit acc;
    acc       = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL cmd_accept: got no handshake for addr %0h expected accept", a);
    end else begin
      sb.push_back('{we: we, rdata: er, err: ee});
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      tick();
      done = (sb.size() == 0) && !rsp_valid && !wb_strb;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d responses outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    int n;
    int r0;
    bit hit;

    #1 rst = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wb_strb", wb_strb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_wb_addr", wb_addr, 0);
    rst = 1'b0;
    tick();

    // 1: write then read back
    send(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
    send(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    drain();

    // 2: ack tied low -> timeout after 16 strobe cycles
    mode = 1;
    send(1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_strb) n++;
      else if (n > 0) break;
    end
    check("tmo_strb_cycles", n, 16);
    tick();
    drain();
    mode = 0;

    // 3: response stalled, FIFO fills, then releases in order
    rsp_ready = 1'b0;
    send(1'b1, 8'h30, 8'h11, 8'h00, 1'b0);
    send(1'b1, 8'h31, 8'h22, 8'h00, 1'b0);
    send(1'b1, 8'h32, 8'h33, 8'h00, 1'b0);
    send(1'b0, 8'h30, 8'h00, 8'h11, 1'b0);
    send(1'b0, 8'h31, 8'h00, 8'h22, 1'b0);
    repeat (4) tick();
    check("full_cmd_ready", cmd_ready, 0);
    check("full_count", dut.u_fifo.count_q, 4);
    check("stall_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    send(1'b0, 8'h32, 8'h00, 8'h33, 1'b0);
    drain();

    // 4: ack arrives in the final timeout cycle -> success
    mode = 2;
    send(1'b0, 8'h50, 8'h00, 8'h3C, 1'b0);
    drain();
    mode = 0;

    // 5: reset in the middle of a transaction
    send(1'b1, 8'h40, 8'h99, 8'h00, 1'b0);
    send(1'b1, 8'h41, 8'h88, 8'h00, 1'b0);
    hit = wb_strb;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      hit = wb_strb;
    end
    check("pre_rst_strb", wb_strb, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_strb", wb_strb, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_count", dut.u_fifo.count_q, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    send(1'b1, 8'h01, 8'h77, 8'h00, 1'b0);
    send(1'b0, 8'h01, 8'h00, 8'h77, 1'b0);
    drain();

    // 6: back-to-back writes at address extremes, then readback
    gap_on = 1'b1;
    r0 = rises;
    send(1'b1, 8'hFF, 8'hC3, 8'h00, 1'b0);
    send(1'b1, 8'h00, 8'h5A, 8'h00, 1'b0);
    send(1'b0, 8'h00, 8'h00, 8'h5A, 1'b0);
    send(1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0);
    drain();
    check("b2b_strb_rises", rises - r0, 4);
    gap_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
